// File: rtl/alu_pkg.sv
// Shared encodings for the R-type issue block.
// Holds the opcode/funct constants, the FSM state type, the instruction field layout and the legality helper.
package alu_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] FUNCT_ADDU = 6'b001011;
    localparam logic [5:0] FUNCT_SUBU = 6'b001101;
    localparam logic [5:0] FUNCT_AND  = 6'b010010;
    localparam logic [5:0] FUNCT_SLL  = 6'b100110;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        ILL  = 3'd4
    } state_e;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

    function automatic logic funct_supported(input logic [5:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADDU, FUNCT_SUBU, FUNCT_AND, FUNCT_SLL: ok = 1'b1;
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rtype_issue_if.sv
// Instruction handshake, register-file, ALU and write-back signals of rtype_issue.
// slave is the issue block's view; master is the environment (register file, ALU, instruction source).
interface rtype_issue_if;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_funct;
    logic [31:0] alu_result;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [15:0] retired;

    modport slave (
        input  inst_valid, inst, rs_data, rt_data, alu_result,
        output inst_ready, rs_addr, rt_addr, alu_src1, alu_src2, alu_shamt,
               alu_funct, wb_en, wb_addr, wb_data, illegal, retired
    );

    modport master (
        output inst_valid, inst, rs_data, rt_data, alu_result,
        input  inst_ready, rs_addr, rt_addr, alu_src1, alu_src2, alu_shamt,
               alu_funct, wb_en, wb_addr, wb_data, illegal, retired
    );

endinterface

// File: rtl/rtype_decode.sv
// Combinational field extraction and legality check for one 32-bit R-type word.
module rtype_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [5:0]  funct_o,
    output logic        legal_o,
    output logic        is_sll_o
);

    rtype_t fields_s;

    assign fields_s = rtype_t'(inst_i);
    assign rs_o     = fields_s.rs;
    assign rt_o     = fields_s.rt;
    assign rd_o     = fields_s.rd;
    assign shamt_o  = fields_s.shamt;
    assign funct_o  = fields_s.funct;
    assign legal_o  = (fields_s.op == OP_RTYPE) && funct_supported(fields_s.funct);
    assign is_sll_o = (fields_s.funct == FUNCT_SLL);

endmodule

// File: rtl/rtype_issue.sv
// Four-cycle R-type issue sequencer: accept, read registers, execute on the external ALU, write back.
// Illegal words take a one-cycle ILL detour that only raises the illegal pulse.
module rtype_issue
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rtype_issue_if.slave bus
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] inst_q;
    logic [15:0] retired_q;
    logic [15:0] retired_d;

    logic        inst_ready_q;
    logic [4:0]  rs_addr_q;
    logic [4:0]  rt_addr_q;
    logic [31:0] alu_src1_q;
    logic [31:0] alu_src2_q;
    logic [4:0]  alu_shamt_q;
    logic [5:0]  alu_funct_q;
    logic        wb_en_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic        illegal_q;

    logic [31:0] dec_in_s;
    logic [4:0]  dec_rs_s;
    logic [4:0]  dec_rt_s;
    logic [4:0]  dec_rd_s;
    logic [4:0]  dec_shamt_s;
    logic [5:0]  dec_funct_s;
    logic        dec_legal_s;
    logic        dec_is_sll_s;

    // In IDLE the decoder judges the offered word; once busy it reads the latched copy.
    assign dec_in_s = (state_q == IDLE) ? bus.inst : inst_q;

    rtype_decode u_decode (
        .inst_i   (dec_in_s),
        .rs_o     (dec_rs_s),
        .rt_o     (dec_rt_s),
        .rd_o     (dec_rd_s),
        .shamt_o  (dec_shamt_s),
        .funct_o  (dec_funct_s),
        .legal_o  (dec_legal_s),
        .is_sll_o (dec_is_sll_s)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.inst_valid) begin
                    state_d = dec_legal_s ? READ : ILL;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            ILL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The count is committed on leaving WB, so a reset during WB discards it.
    always_comb begin
        if (state_q == WB) begin
            retired_d = retired_q + 16'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // FSM state, instruction latch, counter and registered outputs keyed on the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            inst_q       <= 32'd0;
            retired_q    <= 16'd0;
            inst_ready_q <= 1'b1;
            rs_addr_q    <= 5'd0;
            rt_addr_q    <= 5'd0;
            alu_src1_q   <= 32'd0;
            alu_src2_q   <= 32'd0;
            alu_shamt_q  <= 5'd0;
            alu_funct_q  <= 6'd0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= 5'd0;
            wb_data_q    <= 32'd0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            inst_ready_q <= (state_d == IDLE);
            rs_addr_q    <= 5'd0;
            rt_addr_q    <= 5'd0;
            alu_src1_q   <= 32'd0;
            alu_src2_q   <= 32'd0;
            alu_shamt_q  <= 5'd0;
            alu_funct_q  <= 6'd0;
            wb_en_q      <= 1'b0;
            illegal_q    <= 1'b0;
            if ((state_q == IDLE) && bus.inst_valid) begin
                inst_q <= bus.inst;
            end else begin
                inst_q <= inst_q;
            end
            case (state_d)
                READ: begin
                    rs_addr_q <= dec_rs_s;
                    rt_addr_q <= dec_rt_s;
                end
                EXEC: begin
                    // Register data is captured straight into the operand registers.
                    alu_src1_q  <= dec_is_sll_s ? bus.rt_data : bus.rs_data;
                    alu_src2_q  <= dec_is_sll_s ? 32'd0 : bus.rt_data;
                    alu_shamt_q <= dec_is_sll_s ? dec_shamt_s : 5'd0;
                    alu_funct_q <= dec_funct_s;
                end
                WB: begin
                    wb_en_q   <= (dec_rd_s != 5'd0);
                    wb_addr_q <= dec_rd_s;
                    wb_data_q <= bus.alu_result;
                end
                ILL: begin
                    illegal_q <= 1'b1;
                end
                default: begin
                    illegal_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inst_ready = inst_ready_q;
    assign bus.rs_addr    = rs_addr_q;
    assign bus.rt_addr    = rt_addr_q;
    assign bus.alu_src1   = alu_src1_q;
    assign bus.alu_src2   = alu_src2_q;
    assign bus.alu_shamt  = alu_shamt_q;
    assign bus.alu_funct  = alu_funct_q;
    // Reset arriving in the WB cycle itself must still block the write.
    assign bus.wb_en      = wb_en_q & rst_n;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_rtype_issue.sv
// Self-checking bench for rtype_issue: directed scenarios plus random words against a behavioural model.
// The bench owns the register file and the ALU; expected results come from the instruction fields alone.
module tb_rtype_issue;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] regs [32];
    logic [15:0] exp_retired = 16'd0;
    int          n_checks = 0;
    int          n_pass   = 0;

    rtype_issue_if bus ();

    rtype_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rs_data = regs[bus.rs_addr];
    assign bus.rt_data = regs[bus.rt_addr];

    always_comb begin
        case (bus.alu_funct)
            6'b001011: bus.alu_result = bus.alu_src1 + bus.alu_src2;
            6'b001101: bus.alu_result = bus.alu_src1 - bus.alu_src2;
            6'b010010: bus.alu_result = bus.alu_src1 & bus.alu_src2;
            6'b100110: bus.alu_result = bus.alu_src1 << bus.alu_shamt;
            default:   bus.alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Offer one word at the current negedge and follow it to completion, cycle by cycle.
    task automatic run_inst(input logic [31:0] w, input bit hold, input bit chk);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          legal;
        bit          is_sll;
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
        legal  = (op == 6'd0) && (fn == 6'h0b || fn == 6'h0d || fn == 6'h12 || fn == 6'h26);
        is_sll = (fn == 6'h26);
        a = regs[rs];
        b = regs[rt];
        case (fn)
            6'h0b:   exp = a + b;
            6'h0d:   exp = a - b;
            6'h12:   exp = a & b;
            6'h26:   exp = b << sh;
            default: exp = 32'd0;
        endcase
        if (chk) check("ready_idle", bus.inst_ready, 32'd1);
        bus.inst_valid = 1'b1;
        bus.inst       = w;
        @(negedge clk);
        if (hold) bus.inst = $urandom(); else bus.inst_valid = 1'b0;
        if (!legal) begin
            if (chk) begin
                check("ill_pulse", bus.illegal, 32'd1);
                check("ill_no_wb", bus.wb_en, 32'd0);
                check("ill_busy", bus.inst_ready, 32'd0);
            end
            @(negedge clk);
            if (chk) begin
                check("ill_clear", bus.illegal, 32'd0);
                check("ill_ready", bus.inst_ready, 32'd1);
                check("ill_count", bus.retired, exp_retired);
            end
            return;
        end
        if (chk) begin
            check("rd_rs_addr", bus.rs_addr, rs);
            check("rd_rt_addr", bus.rt_addr, rt);
            check("rd_busy", bus.inst_ready, 32'd0);
            check("rd_funct0", bus.alu_funct, 32'd0);
            check("rd_illegal", bus.illegal, 32'd0);
        end
        @(negedge clk);
        if (hold) bus.inst = $urandom();
        if (chk) begin
            check("ex_funct", bus.alu_funct, fn);
            check("ex_src1", bus.alu_src1, is_sll ? b : a);
            check("ex_src2", bus.alu_src2, is_sll ? 32'd0 : b);
            if (is_sll) check("ex_shamt", bus.alu_shamt, sh);
            check("ex_rs_addr0", bus.rs_addr, 32'd0);
            check("ex_no_wb", bus.wb_en, 32'd0);
        end
        @(negedge clk);
        if (hold) bus.inst = $urandom();
        if (chk) begin
            check("wb_en", bus.wb_en, (rd != 5'd0) ? 32'd1 : 32'd0);
            if (rd != 5'd0) begin
                check("wb_addr", bus.wb_addr, rd);
                check("wb_data", bus.wb_data, exp);
            end
            check("wb_funct0", bus.alu_funct, 32'd0);
            check("wb_src1_0", bus.alu_src1, 32'd0);
            check("wb_busy", bus.inst_ready, 32'd0);
        end
        if (rd != 5'd0) regs[rd] = exp;
        exp_retired = exp_retired + 16'd1;
        @(negedge clk);
        if (chk) begin
            check("done_ready", bus.inst_ready, 32'd1);
            check("done_no_wb", bus.wb_en, 32'd0);
            check("done_count", bus.retired, exp_retired);
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst       = 32'd0;
        regs[0] = 32'd0;
        for (int i = 1; i < 32; i++) regs[i] = $urandom();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.inst_ready, 32'd1);
        check("rst_count", bus.retired, 32'd0);
        check("rst_wb_en", bus.wb_en, 32'd0);
        check("rst_illegal", bus.illegal, 32'd0);
        check("rst_funct", bus.alu_funct, 32'd0);

        // Reset during EXEC of addu aborts it.
        regs[1] = 32'h00000005;
        regs[2] = 32'hFFFFFFFF;
        bus.inst_valid = 1'b1;
        bus.inst = enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0b);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        @(negedge clk);
        check("abort_ex_src1", bus.alu_src1, 32'h00000005);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_wb", bus.wb_en, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", bus.inst_ready, 32'd1);
        check("abort_no_wb2", bus.wb_en, 32'd0);
        check("abort_count", bus.retired, exp_retired);

        // addu 5 + 0xFFFFFFFF -> 4
        run_inst(enc(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0b), 1'b0, 1'b1);
        check("addu_r3", regs[3], 32'h00000004);
        check("addu_count1", bus.retired, 32'd1);

        // sll 1 << 31
        regs[4] = 32'h00000001;
        run_inst(enc(6'd0, 5'd7, 5'd4, 5'd5, 5'd31, 6'h26), 1'b0, 1'b1);
        check("sll_r5", regs[5], 32'h80000000);

        // load opcode is illegal, then subu 0x10 - 0x20
        run_inst(enc(6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0b), 1'b0, 1'b1);
        regs[6] = 32'h00000010;
        regs[7] = 32'h00000020;
        run_inst(enc(6'd0, 5'd6, 5'd7, 5'd8, 5'd0, 6'h0d), 1'b0, 1'b1);
        check("subu_r8", regs[8], 32'hFFFFFFF0);
        run_inst(enc(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20), 1'b0, 1'b1);

        // and with rd=0 and back-to-back offers with inst_valid held high
        run_inst(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h12), 1'b1, 1'b1);
        run_inst(enc(6'd0, 5'd3, 5'd4, 5'd10, 5'd0, 6'h0b), 1'b1, 1'b1);
        run_inst(enc(6'd0, 5'd10, 5'd2, 5'd11, 5'd3, 6'h26), 1'b0, 1'b1);

        // Reset asserted during WB suppresses that cycle's write.
        bus.inst_valid = 1'b1;
        bus.inst = enc(6'd0, 5'd1, 5'd2, 5'd12, 5'd0, 6'h0b);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("wbrst_pre", bus.wb_en, 32'd1);
        rst_n = 1'b0;
        #1;
        check("wbrst_no_wb", bus.wb_en, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 16'd0;
        @(negedge clk);
        check("wbrst_ready", bus.inst_ready, 32'd1);
        check("wbrst_count", bus.retired, exp_retired);

        // Random words, mostly legal, sometimes held valid through the busy cycles.
        for (int i = 0; i < 200; i++) begin
            logic [5:0]  fn;
            logic [5:0]  op;
            case ($urandom_range(0, 4))
                0:       fn = 6'h0b;
                1:       fn = 6'h0d;
                2:       fn = 6'h12;
                3:       fn = 6'h26;
                default: fn = 6'($urandom());
            endcase
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_inst(enc(op, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), fn),
                     1'($urandom_range(0, 1)), 1'b1);
        end
        bus.inst_valid = 1'b0;

        // Run the counter up to 0xFFFF with real instructions, then wrap it.
        while (exp_retired != 16'hFFFF) begin
            run_inst(enc(6'd0, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), 6'h0b),
                     1'b1, 1'b0);
        end
        bus.inst_valid = 1'b0;
        check("pre_wrap", bus.retired, 32'h0000FFFF);
        run_inst(enc(6'd0, 5'd1, 5'd2, 5'd13, 5'd0, 6'h12), 1'b0, 1'b1);
        check("wrap_zero", bus.retired, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rtype_issue.md
RTYPE_ISSUE -- requirements
Module: rtype_issue

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, synchronous, active-low reset.
REQ-003 The block SHALL have the port `inst_valid`: input, 1 bit, instruction word offered.
REQ-004 The block SHALL have the port `inst_ready`: output, 1 bit, block can accept an instruction.
REQ-005 The block SHALL have the port `inst`: input, 32 bits, instruction word laid out as op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
REQ-006 The block SHALL have the ports `rs_addr` and `rt_addr`: outputs, 5 bits each, register-file read addresses.
REQ-007 The block SHALL have the ports `rs_data` and `rt_data`: inputs, 32 bits each, combinational register-file read data.
REQ-008 The block SHALL have the ports `alu_src1` and `alu_src2`: outputs, 32 bits each, ALU operands.
REQ-009 The block SHALL have the port `alu_shamt`: output, 5 bits, ALU shift amount.
REQ-010 The block SHALL have the port `alu_funct`: output, 6 bits, ALU operation code.
REQ-011 The block SHALL have the port `alu_result`: input, 32 bits, combinational ALU result.
REQ-012 The block SHALL have the ports `wb_en` (output, 1 bit), `wb_addr` (output, 5 bits) and `wb_data` (output, 32 bits): the register-file write port.
REQ-013 The block SHALL have the port `illegal`: output, 1 bit, one-cycle pulse for an unsupported instruction.
REQ-014 The block SHALL have the port `retired`: output, 16 bits, count of completed legal instructions.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, READ, EXEC, WB and ILL.
REQ-016 `inst_ready` SHALL be 1 only in IDLE; an instruction is accepted on a cycle with `inst_valid` && `inst_ready`, and `inst` is latched whole.
REQ-017 A word SHALL be legal iff op=000000 and funct is one of: addu=001011, subu=001101, and=010010, sll=100110.
REQ-018 Any other op/funct combination SHALL be illegal.
REQ-019 On acceptance, the FSM SHALL go IDLE->READ if the word is legal and IDLE->ILL if it is not.
REQ-020 ILL SHALL assert `illegal` for one cycle, perform no write and no count, then go ->IDLE.
REQ-021 READ SHALL drive `rs_addr`/`rt_addr` from the latched fields, latch `rs_data`/`rt_data` at the end of the cycle, then go ->EXEC.
REQ-022 EXEC SHALL drive the ALU operands as follows, then go ->WB:
  - addu/subu/and: `alu_src1`=rs value, `alu_src2`=rt value.
  - sll: `alu_src1`=rt value, `alu_src2`=0, `alu_shamt`=latched shamt.
  - `alu_funct`=latched funct.
  - `alu_result` is latched at the end of EXEC.
REQ-023 WB SHALL assert `wb_en` for one cycle with `wb_addr`=rd and `wb_data`=the latched result, increment `retired`, then go ->IDLE.
REQ-024 When rd=0, `wb_en` SHALL stay 0 in WB and `retired` SHALL still increment.
REQ-025 Latency SHALL be: acceptance in cycle N produces `wb_en` in cycle N+3, and `inst_ready` returns in cycle N+4; peak throughput is 1 instruction per 4 cycles.
REQ-026 Outside EXEC, `alu_funct` SHALL be 000000 and `alu_src1`, `alu_src2` and `alu_shamt` SHALL be 0.
REQ-027 Outside READ, `rs_addr` and `rt_addr` SHALL be 0.
REQ-028 `retired` SHALL wrap from 0xFFFF to 0x0000.
REQ-029 Add/sub arithmetic SHALL be modulo 2^32 (performed by the ALU); this block performs no arithmetic except the counter.
REQ-030 `inst_valid` held high while the block is busy SHALL be ignored, with no queuing.
REQ-031 A new word SHALL be sampled only on a cycle where IDLE and `inst_valid` coincide.

Reset
REQ-032 With `rst_n`=0 at a rising edge, the block SHALL go to IDLE and clear all latches.
REQ-033 Reset SHALL set `retired`=0, and SHALL set `wb_en`=0 and `illegal`=0.
REQ-034 After reset, `inst_ready`=1 in the cycle following release.
REQ-035 Reset during READ, EXEC or WB SHALL abort the instruction: no write, no count increment.
REQ-036 Reset asserted in the WB cycle SHALL suppress that cycle's `wb_en`.

Structure
REQ-037 The shared package `alu_pkg` SHALL hold the funct constants (addu, subu, and, sll), the R-type opcode constant and the FSM state encoding.
REQ-038 Field extraction and legality checking SHALL be a combinational sub-module, `rtype_decode`, instantiated once.
REQ-039 The FSM, latches and counter SHALL be in the top level.

Verification
REQ-040 Bench scenario: addu with rs=1 (0x00000005), rt=2 (0xFFFFFFFF), rd=3 -> `wb_en` at N+3, `wb_addr`=3, `wb_data`=0x00000004, `retired`=1.
REQ-041 Bench scenario: sll with rt=4 (0x00000001), shamt=31, rd=5 -> `alu_src1`=0x00000001 in EXEC, `wb_data`=0x80000000.
REQ-042 Bench scenario: op=0x23 (load), then a legal subu word -> `illegal` pulses at N+1 with no `wb_en`, then subu 0x10-0x20 writes 0xFFFFFFF0.
REQ-043 Bench scenario: and with rd=0 -> `wb_en` stays 0, `retired` increments; `inst_valid` held high throughout -> exactly one acceptance per 4 cycles.
REQ-044 Bench scenario: `rst_n`=0 during EXEC of addu -> no `wb_en`, `retired` unchanged, `inst_ready`=1 the cycle after release.
REQ-045 Bench scenario: preload `retired`=0xFFFF via 65535 legal instructions, then one more -> `retired`=0x0000.
